// File: rtl/cpu6_bus_pkg.sv
// Shared types and constants for the CPU6 memory-side bus stage.
package cpu6_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XLATE  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [5:0] IO_FRAME_HI = 6'b111111;

    localparam int unsigned WP_BIT    = 7;
    localparam int unsigned FRAME_MSB = 6;
    localparam int unsigned FRAME_LSB = 0;
    localparam int unsigned PAGE_MSB  = 15;
    localparam int unsigned PAGE_LSB  = 11;

    // Frames 7'h7E and 7'h7F are the I/O window.
    function automatic logic is_io_frame(input logic [6:0] frame);
        return frame[6:1] == IO_FRAME_HI;
    endfunction

endpackage

// File: rtl/cpu6_mmu_bus_if.sv
// Core-side request bus, map/context port and physical memory bus of the MMU stage.
interface cpu6_mmu_bus_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_re;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_fault;
    logic        ctx_we;
    logic [1:0]  ctx_wdata;
    logic        map_we;
    logic [6:0]  map_addr;
    logic [7:0]  map_wdata;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_re, cpu_we,
        output ctx_we, ctx_wdata, map_we, map_addr, map_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_busy, cpu_done, cpu_fault,
        input  mem_addr, mem_wdata, mem_re, mem_we
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_re, cpu_we,
        input  ctx_we, ctx_wdata, map_we, map_addr, map_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_busy, cpu_done, cpu_fault,
        output mem_addr, mem_wdata, mem_re, mem_we
    );
endinterface

// File: rtl/cpu6_page_map.sv
// 128-entry page map: {wp, frame[6:0]} per {ctx, page}, resets to identity, unprotected.
module cpu6_page_map (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_we,
    input  logic [6:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [6:0] i_raddr,
    output logic [7:0] o_rdata
);
    logic [7:0] r_mem [128];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 128; i++) begin
                r_mem[i] <= {3'b000, 5'(i)};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read returns the pre-write value during a same-cycle write.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu6_mmu_bus.sv
// CPU6 MMU bus stage: logical->physical translation, write protect, wait-stated bus cycles.
module cpu6_mmu_bus #(
    parameter int unsigned WAIT_MEM = 1,
    parameter int unsigned WAIT_IO  = 3
) (
    input  logic          clock,
    input  logic          reset,
    cpu6_mmu_bus_if.slave bus
);
    import cpu6_bus_pkg::*;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_is_write;
    logic [1:0]  r_ctx;
    logic [3:0]  r_cnt;
    logic [17:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic [7:0]  r_rdata;
    logic        r_fault;

    logic [6:0]  w_map_idx;
    logic [7:0]  w_entry;
    logic [6:0]  w_frame;
    logic        w_accept;
    logic        w_prot;

    assign w_map_idx = {r_ctx, r_addr[PAGE_MSB:PAGE_LSB]};
    assign w_frame   = w_entry[FRAME_MSB:FRAME_LSB];
    assign w_prot    = r_is_write & w_entry[WP_BIT];

    cpu6_page_map u_map (
        .clock   (clock),
        .reset   (reset),
        .i_we    (bus.map_we),
        .i_waddr (bus.map_addr),
        .i_wdata (bus.map_wdata),
        .i_raddr (w_map_idx),
        .o_rdata (w_entry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.cpu_busy  = 1'b1;
        bus.cpu_done  = 1'b0;
        bus.cpu_fault = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.cpu_busy = 1'b0;
                if (bus.cpu_re || bus.cpu_we) begin
                    w_accept = 1'b1;
                    w_next   = ST_XLATE;
                end
            end
            ST_XLATE: w_next = w_prot ? ST_DONE : ST_ACCESS;
            ST_ACCESS: begin
                bus.mem_re = ~r_is_write;
                bus.mem_we = r_is_write;
                if (r_cnt == '0) w_next = ST_DONE;
            end
            ST_DONE: begin
                bus.cpu_done  = 1'b1;
                bus.cpu_fault = r_fault;
                w_next        = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_ctx       <= '0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_fault     <= 1'b0;
        end else begin
            if (bus.ctx_we) r_ctx <= bus.ctx_wdata;
            if (w_accept) begin
                r_addr     <= bus.cpu_addr;
                r_wdata    <= bus.cpu_wdata;
                r_is_write <= bus.cpu_we;
                r_fault    <= 1'b0;
            end
            case (r_state)
                ST_XLATE: begin
                    if (w_prot) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_mem_addr  <= {w_frame, r_addr[PAGE_LSB-1:0]};
                        r_mem_wdata <= r_wdata;
                        r_cnt       <= is_io_frame(w_frame) ? 4'(WAIT_IO) : 4'(WAIT_MEM);
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != '0)      r_cnt   <= r_cnt - 4'd1;
                    else if (!r_is_write) r_rdata <= bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_rdata = r_rdata;

endmodule

// File: tb/tb_cpu6_mmu_bus.sv
// Directed self-checking bench for cpu6_mmu_bus.
module tb_cpu6_mmu_bus;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    cpu6_mmu_bus_if bus ();

    cpu6_mmu_bus #(.WAIT_MEM(1), .WAIT_IO(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          dc, dn, fc, fn, rc, wc;
    logic [17:0] sa;
    logic [7:0]  sw;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic map_wr(input logic [6:0] idx, input logic [7:0] d);
        bus.map_we    = 1'b1;
        bus.map_addr  = idx;
        bus.map_wdata = d;
        tick();
        bus.map_we    = 1'b0;
    endtask

    task automatic ctx_wr(input logic [1:0] c);
        bus.ctx_we    = 1'b1;
        bus.ctx_wdata = c;
        tick();
        bus.ctx_we    = 1'b0;
    endtask

    // Issues one request and observes 12 cycles after accept (cycle numbering: accept = 0).
    task automatic run_req(input logic [15:0] a, input logic [7:0] wd, input logic re,
                           input logic we, input logic [7:0] rd, input int hold,
                           output int done_cyc, output int done_cnt, output int fault_cyc,
                           output int fault_cnt, output int re_cnt, output int we_cnt,
                           output logic [17:0] seen_addr, output logic [7:0] seen_wd);
        done_cyc = 0; done_cnt = 0; fault_cyc = 0; fault_cnt = 0;
        re_cnt = 0; we_cnt = 0; seen_addr = '0; seen_wd = '0;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.mem_rdata = rd;
        bus.cpu_re    = re;
        bus.cpu_we    = we;
        tick();
        for (int c = 1; c <= 12; c++) begin
            if (bus.mem_re) begin re_cnt++; seen_addr = bus.mem_addr; end
            if (bus.mem_we) begin we_cnt++; seen_addr = bus.mem_addr; seen_wd = bus.mem_wdata; end
            if (bus.cpu_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (bus.cpu_fault) begin
                fault_cnt++;
                if (fault_cyc == 0) fault_cyc = c;
            end
            if (c > hold) begin
                bus.cpu_re = 1'b0;
                bus.cpu_we = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_re = 1'b0; bus.cpu_we = 1'b0;
        bus.ctx_we = 1'b0; bus.ctx_wdata = '0; bus.map_we = 1'b0; bus.map_addr = '0;
        bus.map_wdata = '0; bus.mem_rdata = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        chk("rst_busy",  32'(bus.cpu_busy),  32'h0);
        chk("rst_done",  32'(bus.cpu_done),  32'h0);
        chk("rst_mem_re", 32'(bus.mem_re),   32'h0);
        chk("rst_mem_we", 32'(bus.mem_we),   32'h0);
        chk("rst_addr",  32'(bus.mem_addr),  32'h0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 32'h0);

        // Identity read, WAIT_MEM = 1
        run_req(16'h1234, 8'h00, 1'b1, 1'b0, 8'hA5, 0, dc, dn, fc, fn, rc, wc, sa, sw);
        chk("rd_addr",   32'(sa), 32'h01234);
        chk("rd_re_len", 32'(rc), 32'd2);
        chk("rd_we_len", 32'(wc), 32'd0);
        chk("rd_done_cyc", 32'(dc), 32'd4);
        chk("rd_done_cnt", 32'(dn), 32'd1);
        chk("rd_rdata",  32'(bus.cpu_rdata), 32'hA5);

        // Write to I/O frame 7F, WAIT_IO = 3
        map_wr(7'h02, 8'h7F);
        run_req(16'h1000, 8'h3C, 1'b0, 1'b1, 8'h00, 0, dc, dn, fc, fn, rc, wc, sa, sw);
        chk("io_addr",   32'(sa), 32'h3F800);
        chk("io_we_len", 32'(wc), 32'd4);
        chk("io_wdata",  32'(sw), 32'h3C);
        chk("io_done_cyc", 32'(dc), 32'd6);
        chk("io_rdata_kept", 32'(bus.cpu_rdata), 32'hA5);

        // Protected write in context 2
        map_wr(7'h41, 8'h85);
        ctx_wr(2'd2);
        run_req(16'h0800, 8'h99, 1'b0, 1'b1, 8'h00, 0, dc, dn, fc, fn, rc, wc, sa, sw);
        chk("wp_fault_cyc", 32'(fc), 32'd2);
        chk("wp_fault_cnt", 32'(fn), 32'd1);
        chk("wp_done_cyc",  32'(dc), 32'd2);
        chk("wp_we_len",    32'(wc), 32'd0);
        chk("wp_rdata_kept", 32'(bus.cpu_rdata), 32'hA5);

        // Read of the protected page ignores protect
        run_req(16'h0800, 8'h00, 1'b1, 1'b0, 8'h5A, 0, dc, dn, fc, fn, rc, wc, sa, sw);
        chk("wpr_addr",  32'(sa), 32'h02800);
        chk("wpr_fault", 32'(fn), 32'd0);
        chk("wpr_done_cyc", 32'(dc), 32'd4);
        chk("wpr_rdata", 32'(bus.cpu_rdata), 32'h5A);

        // re+we together is a write; held requests while busy are ignored
        ctx_wr(2'd0);
        run_req(16'h0005, 8'hE7, 1'b1, 1'b1, 8'h11, 3, dc, dn, fc, fn, rc, wc, sa, sw);
        chk("both_we_len", 32'(wc), 32'd2);
        chk("both_re_len", 32'(rc), 32'd0);
        chk("both_addr",   32'(sa), 32'h00005);
        chk("both_wdata",  32'(sw), 32'hE7);
        chk("both_done_cnt", 32'(dn), 32'd1);
        chk("both_rdata_kept", 32'(bus.cpu_rdata), 32'h5A);

        // Reset in the middle of ACCESS
        ctx_wr(2'd2);
        bus.cpu_addr  = 16'h1234;
        bus.cpu_re    = 1'b1;
        tick();
        bus.cpu_re    = 1'b0;
        tick();
        chk("mid_re_before", 32'(bus.mem_re), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_re_async", 32'(bus.mem_re),   32'h0);
        chk("mid_busy",     32'(bus.cpu_busy), 32'h0);
        tick();
        reset = 1'b0;
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.cpu_done) dn++;
            tick();
        end
        chk("mid_no_done", 32'(dn), 32'd0);

        // ctx back to 0: entry 0x01 (ctx 0, page 1) steers the lookup
        map_wr(7'h01, 8'h10);
        run_req(16'h0800, 8'h00, 1'b1, 1'b0, 8'h33, 0, dc, dn, fc, fn, rc, wc, sa, sw);
        chk("post_ctx0_addr", 32'(sa), 32'h08000);
        chk("post_ctx0_rdata", 32'(bus.cpu_rdata), 32'h33);
        // Map entry 0x02 back to identity, ordinary memory timing
        run_req(16'h1000, 8'h00, 1'b1, 1'b0, 8'h44, 0, dc, dn, fc, fn, rc, wc, sa, sw);
        chk("post_id_addr", 32'(sa), 32'h01000);
        chk("post_id_done_cyc", 32'(dc), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
